// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// Four-bit ripple-carry adder slice made of chained full adders.
module nibble_serial_adder_rca4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NibbleW-1:0] a_i,
  input  logic [NibbleW-1:0] b_i,
  input  logic               c_i,
  output logic [NibbleW-1:0] s_o,
  output logic               c_o
);

  logic [NibbleW:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < NibbleW; i++) begin : g_fa
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o = carry[NibbleW];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential adder: one nibble per clock through a single 4-bit RCA slice,
// carry held in a register, with a start/busy/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NIB  = WIDTH / NibbleW;
  localparam int unsigned CntW = $clog2(NIB);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIB - 1);

  state_e                   state_q, state_d;
  logic [WIDTH-1:0]         a_sh_q, a_sh_d;
  logic [WIDTH-1:0]         b_sh_q, b_sh_d;
  // Holds the NIB-1 nibbles already produced; the final nibble joins on the last edge.
  logic [WIDTH-NibbleW-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]         acc_shift;
  logic [WIDTH-1:0]         sum_q, sum_d;
  logic                     carry_q, carry_d;
  logic                     cout_q, cout_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [NibbleW-1:0]       slice_sum;
  logic                     slice_cout;

  nibble_serial_adder_rca4 u_rca4 (
    .a_i (a_sh_q[NibbleW-1:0]),
    .b_i (b_sh_q[NibbleW-1:0]),
    .c_i (carry_q),
    .s_o (slice_sum),
    .c_o (slice_cout)
  );

  assign acc_shift = {slice_sum, acc_q};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d  = a_sh_q >> NibbleW;
        b_sh_d  = b_sh_q >> NibbleW;
        carry_d = slice_cout;
        acc_d   = acc_shift[WIDTH-1:NibbleW];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          sum_d   = acc_shift;
          cout_d  = slice_cout;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder against a plain-arithmetic model.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  // Presents operands with start for one edge, then scrambles the inputs.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc);
    a = ta; b = tbv; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Samples #1 after each edge until done; lat counts edges after the capture edge.
  task automatic wait_done(input int poke_at, output int lat, output int busy_n,
                           output bit overlap, output bit moved,
                           output logic [W-1:0] s, output logic c);
    logic [W-1:0] s0;
    logic         c0;
    s0 = sum; c0 = cout;
    lat = -1; busy_n = 0; overlap = 1'b0; moved = 1'b0;
    for (int k = 0; k <= 4 * NIB; k++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
      if (sum !== s0 || cout !== c0) moved = 1'b1;
      if (k == poke_at) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    s = sum; c = cout;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got=%b want=0", done); end
    if (sum !== '0) begin bad++; $display("FAIL reset_sum: got=%h want=0", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got=%b want=0", cout); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [W-1:0] vb [4] = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0000};
    logic         vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] vs [4] = '{16'h2233, 16'h0000, 16'h0000, 16'h0000};
    logic         vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat, bn; bit ov, mv; logic [W-1:0] s; logic c;
    for (int i = 0; i < 4; i++) begin
      launch(va[i], vb[i], vc[i]);
      wait_done(-1, lat, bn, ov, mv, s, c);
      total += 6;
      if (lat != NIB) begin bad++; $display("FAIL dir%0d_latency: got=%0d want=%0d", i, lat, NIB); end
      if (bn != NIB) begin bad++; $display("FAIL dir%0d_busy_cycles: got=%0d want=%0d", i, bn, NIB); end
      if (ov) begin bad++; $display("FAIL dir%0d_busy_done_overlap: got=1 want=0", i); end
      if (mv) begin bad++; $display("FAIL dir%0d_sum_stable: got=moved want=held", i); end
      if (s !== vs[i]) begin bad++; $display("FAIL dir%0d_sum: got=%h want=%h", i, s, vs[i]); end
      if (c !== vo[i]) begin bad++; $display("FAIL dir%0d_cout: got=%b want=%b", i, c, vo[i]); end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL dir%0d_idle_after: got=busy%b/done%b want=0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, bn; bit ov, mv; logic [W-1:0] s; logic c;
    launch(16'h00FF, 16'h0001, 1'b0);
    wait_done(1, lat, bn, ov, mv, s, c);
    total += 4;
    if (lat != NIB) begin bad++; $display("FAIL ignore_latency: got=%0d want=%0d", lat, NIB); end
    if (mv) begin bad++; $display("FAIL ignore_sum_stable: got=moved want=held"); end
    if (s !== 16'h0100) begin bad++; $display("FAIL ignore_sum: got=%h want=0100", s); end
    if (c !== 1'b0) begin bad++; $display("FAIL ignore_cout: got=%b want=0", c); end
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart: got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit ov, mv; logic [W-1:0] s; logic c;
    launch(16'h1111, 16'h2222, 1'b0);
    wait_done(-1, lat, bn, ov, mv, s, c);
    total++;
    if (s !== 16'h3333) begin bad++; $display("FAIL b2b_first_sum: got=%h want=3333", s); end
    launch(16'h8000, 16'h8000, 1'b0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble: got=%b want=1", busy); end
    wait_done(-1, lat, bn, ov, mv, s, c);
    total += 4;
    if (lat != NIB) begin bad++; $display("FAIL b2b_latency: got=%0d want=%0d", lat, NIB); end
    if (mv) begin bad++; $display("FAIL b2b_sum_stable: got=moved want=held"); end
    if (s !== 16'h0000) begin bad++; $display("FAIL b2b_sum: got=%h want=0000", s); end
    if (c !== 1'b1) begin bad++; $display("FAIL b2b_cout: got=%b want=1", c); end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn; bit ov, mv, saw_done; logic [W-1:0] s; logic c;
    @(posedge clk); #1;
    launch(16'h0F0F, 16'h0101, 1'b0);
    wait_done(-1, lat, bn, ov, mv, s, c);
    launch(16'h7777, 16'h1111, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total += 4;
    if (sum !== '0) begin bad++; $display("FAIL midrst_sum: got=%h want=0", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL midrst_cout: got=%b want=0", cout); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got=%b want=0", done); end
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL midrst_no_done: got=activity want=idle"); end
    launch(16'h7777, 16'h1111, 1'b1);
    wait_done(-1, lat, bn, ov, mv, s, c);
    total += 2;
    if (lat != NIB) begin bad++; $display("FAIL midrst_latency: got=%0d want=%0d", lat, NIB); end
    if ({c, s} !== 17'h08889) begin bad++; $display("FAIL midrst_result: got=%h want=08889", {c, s}); end
  endtask

  task automatic test_random();
    int lat, bn, gap; bit ov, mv; logic [W-1:0] s, ta, tbv; logic c, tc;
    logic [W:0] expect_v;
    for (int i = 0; i < 40; i++) begin
      ta = W'($urandom); tbv = W'($urandom); tc = 1'($urandom);
      if (i % 8 == 0) ta = '1;
      expect_v = {1'b0, ta} + {1'b0, tbv} + (W + 1)'(tc);
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      launch(ta, tbv, tc);
      wait_done(-1, lat, bn, ov, mv, s, c);
      total += 3;
      if (lat != NIB) begin bad++; $display("FAIL rnd%0d_latency: got=%0d want=%0d", i, lat, NIB); end
      if (ov) begin bad++; $display("FAIL rnd%0d_overlap: got=1 want=0", i); end
      if ({c, s} !== expect_v) begin
        bad++; $display("FAIL rnd%0d_result: a=%h b=%h cin=%b got=%h want=%h", i, ta, tbv, tc, {c, s}, expect_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
